// File: rtl/frog_pkg.sv
// Shared types and the coordinate clamp used by the frog hop controller.
package frog_pkg;

  typedef enum logic [2:0] {DirNone, DirUp, DirDown, DirLeft, DirRight} dir_t;

  typedef enum logic [1:0] {StIdle, StHop, StCool} hop_state_t;

  typedef logic [10:0] coord_t;

  // Position intermediates: wide enough for coord + hop step + drift with sign.
  typedef logic signed [12:0] pos_t;

  function automatic coord_t clamp(input pos_t v, input pos_t lim);
    pos_t r;
    if (v < 0) begin
      r = '0;
    end else if (v > lim) begin
      r = lim;
    end else begin
      r = v;
    end
    return r[10:0];
  endfunction

endpackage

// File: rtl/frog_hop_ctrl_if.sv
// Keyboard/game-control inputs and sprite/status outputs of the frog hop controller.
interface frog_hop_ctrl_if
  import frog_pkg::*;
#(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned DRIFT_W   = 4
);

  logic                           timer_done;
  logic                           reset_position;
  logic                           jump;
  coord_t                         jumptoX;
  coord_t                         jumptoY;
  logic                           up;
  logic                           down;
  logic                           left;
  logic                           right;
  logic [NUM_LANES*DRIFT_W-1:0]   lane_speed;
  coord_t                         ObjectStartX;
  coord_t                         ObjectStartY;
  logic                           hopping;
  logic                           hop_done;
  logic                           edge_hit;
  logic [3:0]                     lane_idx;

  modport master (
    output timer_done, reset_position, jump, jumptoX, jumptoY,
    output up, down, left, right, lane_speed,
    input  ObjectStartX, ObjectStartY, hopping, hop_done, edge_hit, lane_idx
  );

  modport slave (
    input  timer_done, reset_position, jump, jumptoX, jumptoY,
    input  up, down, left, right, lane_speed,
    output ObjectStartX, ObjectStartY, hopping, hop_done, edge_hit, lane_idx
  );

endinterface

// File: rtl/frog_lane_lookup.sv
// Maps the sprite centre row to a lane index and selects that lane's signed drift.
module frog_lane_lookup #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned LANE_Y0   = 40,
  parameter int unsigned LANE_H    = 40,
  parameter int unsigned DRIFT_W   = 4
) (
  input  logic [11:0]                    i_cy,
  input  logic [NUM_LANES*DRIFT_W-1:0]   i_lane_speed,
  output logic [3:0]                     o_lane_idx,
  output logic signed [DRIFT_W-1:0]      o_drift
);

  logic [31:0] w_cy32;

  assign w_cy32 = 32'(i_cy);

  // Lane bands are disjoint, so at most one compare in the chain matches.
  always_comb begin
    o_lane_idx = 4'hF;
    o_drift    = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if ((w_cy32 >= 32'(LANE_Y0 + i * LANE_H)) &&
          (w_cy32 <  32'(LANE_Y0 + (i + 1) * LANE_H))) begin
        o_lane_idx = 4'(i);
        o_drift    = i_lane_speed[i*DRIFT_W +: DRIFT_W];
      end
    end
  end

endmodule

// File: rtl/frog_hop_ctrl.sv
// Grid-hopping frog position controller with per-lane drift, cooldown and a one-deep key buffer.
module frog_hop_ctrl
  import frog_pkg::*;
#(
  parameter int unsigned X_MAX      = 639,
  parameter int unsigned Y_MAX      = 479,
  parameter int unsigned SIZE       = 20,
  parameter int unsigned START_X    = 320,
  parameter int unsigned START_Y    = 440,
  parameter int unsigned HOP_STEP   = 20,
  parameter int unsigned HOP_FRAMES = 4,
  parameter int unsigned COOLDOWN   = 2,
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned LANE_Y0    = 40,
  parameter int unsigned LANE_H     = 40,
  parameter int unsigned DRIFT_W    = 4
) (
  input logic            CLK,
  input logic            RESETn,
  frog_hop_ctrl_if.slave bus
);

  localparam pos_t        XLim    = pos_t'(X_MAX + 1 - SIZE);
  localparam pos_t        YLim    = pos_t'(Y_MAX + 1 - SIZE);
  localparam pos_t        StepPx  = pos_t'(HOP_STEP / HOP_FRAMES);
  localparam coord_t      StartX  = coord_t'(START_X);
  localparam coord_t      StartY  = coord_t'(START_Y);
  localparam int unsigned CntMax  = (HOP_FRAMES > COOLDOWN) ? HOP_FRAMES : COOLDOWN;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HopLast = CntW'(HOP_FRAMES - 1);

  coord_t             r_x;
  coord_t             r_y;
  hop_state_t         r_state;
  dir_t               r_pend;
  dir_t               r_hop_dir;
  logic [CntW-1:0]    r_cnt;
  logic               r_hop_done;
  logic               r_edge_hit;

  dir_t                       w_dir;
  logic [11:0]                w_cy;
  logic [3:0]                 w_lane_idx;
  logic signed [DRIFT_W-1:0]  w_drift;
  pos_t                       w_drift_ext;
  pos_t                       w_dx;
  pos_t                       w_dy;
  pos_t                       w_pre_x;
  pos_t                       w_pre_y;
  logic                       w_edge;
  logic                       w_latch;

  assign w_cy = 12'(r_y) + 12'(SIZE / 2);

  frog_lane_lookup #(
    .NUM_LANES (NUM_LANES),
    .LANE_Y0   (LANE_Y0),
    .LANE_H    (LANE_H),
    .DRIFT_W   (DRIFT_W)
  ) u_lane_lookup (
    .i_cy         (w_cy),
    .i_lane_speed (bus.lane_speed),
    .o_lane_idx   (w_lane_idx),
    .o_drift      (w_drift)
  );

  always_comb begin
    w_dir = DirNone;
    if (bus.up) begin
      w_dir = DirUp;
    end else if (bus.down) begin
      w_dir = DirDown;
    end else if (bus.left) begin
      w_dir = DirLeft;
    end else if (bus.right) begin
      w_dir = DirRight;
    end
  end

  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if (r_state == StHop) begin
      case (r_hop_dir)
        DirUp:    w_dy = -StepPx;
        DirDown:  w_dy = StepPx;
        DirLeft:  w_dx = -StepPx;
        DirRight: w_dx = StepPx;
        default:  ;
      endcase
    end
  end

  assign w_drift_ext = {{(13 - DRIFT_W){w_drift[DRIFT_W-1]}}, w_drift};
  assign w_pre_x     = pos_t'({2'b00, r_x}) + w_dx + w_drift_ext;
  assign w_pre_y     = pos_t'({2'b00, r_y}) + w_dy;
  assign w_edge      = ((w_pre_x < 0) || (w_pre_x > XLim)) && (w_drift_ext != '0);
  // Only the first key seen during a hop or cooldown is buffered.
  assign w_latch     = (w_dir != DirNone) && (r_pend == DirNone);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_x        <= StartX;
      r_y        <= StartY;
      r_state    <= StIdle;
      r_pend     <= DirNone;
      r_hop_dir  <= DirNone;
      r_cnt      <= '0;
      r_hop_done <= 1'b0;
      r_edge_hit <= 1'b0;
    end else begin
      r_hop_done <= 1'b0;
      r_edge_hit <= 1'b0;
      if (bus.reset_position) begin
        r_x     <= StartX;
        r_y     <= StartY;
        r_state <= StIdle;
        r_pend  <= DirNone;
        r_cnt   <= '0;
      end else if (bus.jump) begin
        r_x     <= clamp(pos_t'({2'b00, bus.jumptoX}), XLim);
        r_y     <= clamp(pos_t'({2'b00, bus.jumptoY}), YLim);
        r_state <= StIdle;
        r_pend  <= DirNone;
        r_cnt   <= '0;
      end else if (bus.timer_done) begin
        r_x        <= clamp(w_pre_x, XLim);
        r_y        <= clamp(w_pre_y, YLim);
        r_edge_hit <= w_edge;
        case (r_state)
          StIdle: begin
            if ((r_pend != DirNone) || (w_dir != DirNone)) begin
              r_hop_dir <= (r_pend != DirNone) ? r_pend : w_dir;
              r_cnt     <= '0;
              r_pend    <= DirNone;
              r_state   <= StHop;
            end
          end
          StHop: begin
            if (w_latch) r_pend <= w_dir;
            if (r_cnt == HopLast) begin
              r_hop_done <= 1'b1;
              r_cnt      <= '0;
              r_state    <= StCool;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          StCool: begin
            if (w_latch) r_pend <= w_dir;
            if ((32'(r_cnt) + 32'd1) >= 32'(COOLDOWN)) begin
              r_cnt   <= '0;
              r_state <= StIdle;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.ObjectStartX = r_x;
  assign bus.ObjectStartY = r_y;
  assign bus.hopping      = (r_state == StHop);
  assign bus.hop_done     = r_hop_done;
  assign bus.edge_hit     = r_edge_hit;
  assign bus.lane_idx     = w_lane_idx;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed scenario bench for frog_hop_ctrl with hand-computed expected coordinates.
module tb_frog_hop_ctrl;

  logic CLK;
  logic RESETn;
  int   n_tests;
  int   n_fail;

  frog_hop_ctrl_if #(.NUM_LANES(8), .DRIFT_W(4)) bus ();

  frog_hop_ctrl u_dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clr_inputs();
    bus.timer_done     = 1'b0;
    bus.reset_position = 1'b0;
    bus.jump           = 1'b0;
    bus.jumptoX        = '0;
    bus.jumptoY        = '0;
    bus.up             = 1'b0;
    bus.down           = 1'b0;
    bus.left           = 1'b0;
    bus.right          = 1'b0;
    bus.lane_speed     = '0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    @(negedge CLK);
    bus.timer_done = 1'b1;
    @(posedge CLK);
    #1;
    bus.timer_done = 1'b0;
  endtask

  task automatic respawn();
    bus.reset_position = 1'b1;
    cyc();
    bus.reset_position = 1'b0;
  endtask

  task automatic do_jump(input int x, input int y);
    bus.jump    = 1'b1;
    bus.jumptoX = 11'(x);
    bus.jumptoY = 11'(y);
    cyc();
    bus.jump = 1'b0;
  endtask

  task automatic test_reset();
    clr_inputs();
    RESETn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_tests++;
    if (bus.ObjectStartX !== 11'd320 || bus.ObjectStartY !== 11'd440) begin
      n_fail++;
      $display("FAIL reset_pos: got (%0d,%0d) want (320,440)", bus.ObjectStartX, bus.ObjectStartY);
    end
    n_tests++;
    if (bus.hopping !== 1'b0 || bus.hop_done !== 1'b0 || bus.edge_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got hop=%b done=%b edge=%b want 0 0 0",
               bus.hopping, bus.hop_done, bus.edge_hit);
    end
    n_tests++;
    if (bus.lane_idx !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_lane: got %h want F", bus.lane_idx);
    end
    @(negedge CLK);
    RESETn = 1'b1;
    cyc();
  endtask

  task automatic test_hop_up();
    int exp_y[4] = '{435, 430, 425, 420};
    respawn();
    bus.up = 1'b1;
    tick();
    bus.up = 1'b0;
    n_tests++;
    if (bus.hopping !== 1'b1 || bus.ObjectStartY !== 11'd440) begin
      n_fail++;
      $display("FAIL hop_launch: got hop=%b y=%0d want 1 440", bus.hopping, bus.ObjectStartY);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (bus.ObjectStartY !== 11'(exp_y[i]) || bus.hop_done !== (i == 3)) begin
        n_fail++;
        $display("FAIL hop_frame%0d: got y=%0d done=%b want y=%0d done=%b",
                 i, bus.ObjectStartY, bus.hop_done, exp_y[i], (i == 3));
      end
    end
    cyc();
    n_tests++;
    if (bus.hop_done !== 1'b0 || bus.hopping !== 1'b0) begin
      n_fail++;
      $display("FAIL hop_done_width: got done=%b hop=%b want 0 0", bus.hop_done, bus.hopping);
    end
    tick();
    tick();
    bus.up = 1'b1;
    tick();
    bus.up = 1'b0;
    n_tests++;
    if (bus.hopping !== 1'b1) begin
      n_fail++;
      $display("FAIL cool_len: got hop=%b want 1 after two cooldown ticks", bus.hopping);
    end
  endtask

  task automatic test_pending();
    respawn();
    bus.up = 1'b1;
    tick();
    bus.up = 1'b0;
    tick();
    bus.left = 1'b1;
    tick();
    bus.left = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.ObjectStartY !== 11'd420 || bus.ObjectStartX !== 11'd320 || bus.hop_done !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_first: got (%0d,%0d) done=%b want (320,420) 1",
               bus.ObjectStartX, bus.ObjectStartY, bus.hop_done);
    end
    tick();
    tick();
    tick();
    n_tests++;
    if (bus.hopping !== 1'b1 || bus.ObjectStartX !== 11'd320) begin
      n_fail++;
      $display("FAIL pend_launch: got hop=%b x=%0d want 1 320", bus.hopping, bus.ObjectStartX);
    end
    repeat (4) tick();
    n_tests++;
    if (bus.ObjectStartX !== 11'd300 || bus.ObjectStartY !== 11'd420 || bus.hop_done !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_end: got (%0d,%0d) done=%b want (300,420) 1",
               bus.ObjectStartX, bus.ObjectStartY, bus.hop_done);
    end
  endtask

  task automatic test_drift_edge();
    respawn();
    do_jump(2, 100);
    bus.lane_speed[7:4] = 4'hD;
    #1;
    n_tests++;
    if (bus.lane_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL drift_lane: got %0d want 1", bus.lane_idx);
    end
    tick();
    n_tests++;
    if (bus.ObjectStartX !== 11'd0 || bus.edge_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_left1: got x=%0d edge=%b want 0 1", bus.ObjectStartX, bus.edge_hit);
    end
    cyc();
    n_tests++;
    if (bus.edge_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_width: got %b want 0", bus.edge_hit);
    end
    tick();
    n_tests++;
    if (bus.ObjectStartX !== 11'd0 || bus.edge_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_left2: got x=%0d edge=%b want 0 1", bus.ObjectStartX, bus.edge_hit);
    end
    do_jump(618, 100);
    bus.lane_speed[7:4] = 4'h5;
    tick();
    n_tests++;
    if (bus.ObjectStartX !== 11'd620 || bus.edge_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_right: got x=%0d edge=%b want 620 1", bus.ObjectStartX, bus.edge_hit);
    end
    bus.lane_speed = '0;
    tick();
    n_tests++;
    if (bus.ObjectStartX !== 11'd620 || bus.edge_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_nodrift: got x=%0d edge=%b want 620 0", bus.ObjectStartX, bus.edge_hit);
    end
    do_jump(300, 100);
    bus.lane_speed[7:4] = 4'h3;
    tick();
    n_tests++;
    if (bus.ObjectStartX !== 11'd303 || bus.edge_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL drift_plain: got x=%0d edge=%b want 303 0", bus.ObjectStartX, bus.edge_hit);
    end
    bus.lane_speed = '0;
  endtask

  task automatic test_jump_abort();
    respawn();
    bus.up = 1'b1;
    tick();
    bus.up = 1'b0;
    tick();
    tick();
    bus.jump    = 1'b1;
    bus.jumptoX = 11'd500;
    bus.jumptoY = 11'd200;
    tick();
    bus.jump = 1'b0;
    n_tests++;
    if (bus.ObjectStartX !== 11'd500 || bus.ObjectStartY !== 11'd200) begin
      n_fail++;
      $display("FAIL jump_pos: got (%0d,%0d) want (500,200)", bus.ObjectStartX, bus.ObjectStartY);
    end
    n_tests++;
    if (bus.hopping !== 1'b0 || bus.hop_done !== 1'b0 || bus.lane_idx !== 4'd4) begin
      n_fail++;
      $display("FAIL jump_state: got hop=%b done=%b lane=%0d want 0 0 4",
               bus.hopping, bus.hop_done, bus.lane_idx);
    end
    tick();
    n_tests++;
    if (bus.ObjectStartY !== 11'd200 || bus.hopping !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_idle: got y=%0d hop=%b want 200 0", bus.ObjectStartY, bus.hopping);
    end
    do_jump(2047, 2047);
    n_tests++;
    if (bus.ObjectStartX !== 11'd620 || bus.ObjectStartY !== 11'd460) begin
      n_fail++;
      $display("FAIL jump_clamp: got (%0d,%0d) want (620,460)", bus.ObjectStartX, bus.ObjectStartY);
    end
  endtask

  task automatic test_reset_vs_jump();
    respawn();
    bus.up = 1'b1;
    tick();
    bus.up   = 1'b0;
    bus.left = 1'b1;
    tick();
    bus.left           = 1'b0;
    bus.reset_position = 1'b1;
    bus.jump           = 1'b1;
    bus.jumptoX        = 11'd100;
    bus.jumptoY        = 11'd100;
    cyc();
    bus.reset_position = 1'b0;
    bus.jump           = 1'b0;
    n_tests++;
    if (bus.ObjectStartX !== 11'd320 || bus.ObjectStartY !== 11'd440 || bus.hopping !== 1'b0) begin
      n_fail++;
      $display("FAIL rp_priority: got (%0d,%0d) hop=%b want (320,440) 0",
               bus.ObjectStartX, bus.ObjectStartY, bus.hopping);
    end
    tick();
    tick();
    n_tests++;
    if (bus.hopping !== 1'b0 || bus.ObjectStartX !== 11'd320) begin
      n_fail++;
      $display("FAIL rp_pend_clr: got hop=%b x=%0d want 0 320", bus.hopping, bus.ObjectStartX);
    end
  endtask

  task automatic test_async_reset();
    respawn();
    bus.up = 1'b1;
    tick();
    bus.up = 1'b0;
    tick();
    #3;
    RESETn = 1'b0;
    #1;
    n_tests++;
    if (bus.ObjectStartX !== 11'd320 || bus.ObjectStartY !== 11'd440 || bus.hopping !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got (%0d,%0d) hop=%b want (320,440) 0",
               bus.ObjectStartX, bus.ObjectStartY, bus.hopping);
    end
    @(negedge CLK);
    RESETn = 1'b1;
    cyc();
    do_jump(320, 460);
    bus.down = 1'b1;
    tick();
    bus.down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (bus.ObjectStartY !== 11'd460 || bus.hop_done !== (i == 3)) begin
        n_fail++;
        $display("FAIL ylim_hop%0d: got y=%0d done=%b want 460 %b",
                 i, bus.ObjectStartY, bus.hop_done, (i == 3));
      end
    end
  endtask

  task automatic test_lane_map();
    int ys[6]    = '{20, 30, 69, 70, 349, 350};
    int lanes[6] = '{15, 0, 0, 1, 7, 15};
    for (int i = 0; i < 6; i++) begin
      do_jump(100, ys[i]);
      n_tests++;
      if (bus.lane_idx !== 4'(lanes[i])) begin
        n_fail++;
        $display("FAIL lane_map_y%0d: got %0d want %0d", ys[i], bus.lane_idx, lanes[i]);
      end
    end
  endtask

  task automatic test_key_priority();
    do_jump(320, 200);
    bus.left  = 1'b1;
    bus.down  = 1'b1;
    bus.right = 1'b1;
    tick();
    bus.left  = 1'b0;
    bus.down  = 1'b0;
    bus.right = 1'b0;
    tick();
    n_tests++;
    if (bus.ObjectStartY !== 11'd205 || bus.ObjectStartX !== 11'd320) begin
      n_fail++;
      $display("FAIL key_prio: got (%0d,%0d) want (320,205)", bus.ObjectStartX, bus.ObjectStartY);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_hop_up();
    test_pending();
    test_drift_edge();
    test_jump_abort();
    test_reset_vs_jump();
    test_async_reset();
    test_lane_map();
    test_key_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frog_hop_ctrl.md
Name: frog_hop_ctrl

Overview:
- Parametrised successor to the continuous frog mover. Produces the sprite top-left coordinate from keys, game-control events and per-lane current drift.
- Movement is grid hops: one key press is one HOP_STEP-pixel hop, animated over HOP_FRAMES frame ticks. A cooldown and a one-deep key buffer follow each hop.
- Drift speed and direction are per lane and supplied at runtime. Sits between the keyboard decoder and the sprite drawer / collision logic.

Parameters:
- X_MAX, 639, last visible pixel column
- Y_MAX, 479, last visible pixel row
- SIZE, 20, sprite side in pixels
- START_X, 320, reset/respawn X
- START_Y, 440, reset/respawn Y
- HOP_STEP, 20, pixels per hop; must be a multiple of HOP_FRAMES
- HOP_FRAMES, 4, frame ticks per hop (>=1)
- COOLDOWN, 2, idle frame ticks after a hop before the next may launch
- NUM_LANES, 8, drift lanes
- LANE_Y0, 40, top row of lane 0
- LANE_H, 40, lane height in pixels
- DRIFT_W, 4, signed width of each lane speed

Ports:
- CLK  in  1  system clock
- RESETn  in  1  asynchronous active-low reset
- timer_done  in  1  one-cycle frame tick
- reset_position  in  1  respawn at START
- jump  in  1  teleport request
- jumptoX  in  11  teleport X
- jumptoY  in  11  teleport Y
- up, down, left, right  in  1 each  key levels
- lane_speed  in  NUM_LANES*DRIFT_W  packed signed px/frame; lane i at [i*DRIFT_W +: DRIFT_W]; positive means +X
- ObjectStartX  out  11  sprite X
- ObjectStartY  out  11  sprite Y
- hopping  out  1  high while in HOP
- hop_done  out  1  one-cycle pulse on the final hop frame
- edge_hit  out  1  one-cycle pulse when drift clamps X at a screen edge
- lane_idx  out  4  current lane, or 4'hF when outside the lane region

Behaviour:
- Limits: X_LIM = X_MAX+1-SIZE (620), Y_LIM = Y_MAX+1-SIZE (460). All position math uses 13-bit signed intermediates. Results are clamped to [0, X_LIM] and [0, Y_LIM] before being registered.
- Async reset sets:
  - ObjectStartX = START_X, ObjectStartY = START_Y
  - state = IDLE, pending = NONE, frame counter = 0
  - hop_done = 0, edge_hit = 0
- Priority each cycle: reset_position > jump > timer_done.
  - reset_position: position = START, state = IDLE, pending = NONE, counter = 0.
  - jump: position = clamped jumpto, state = IDLE, pending = NONE. An in-flight hop is aborted.
  - No other cycle changes any register.
- Key decode: dir = up > down > left > right (first active wins). up means -Y, down +Y, left -X, right +X.
- States:
  - IDLE: on a tick with dir != NONE or pending != NONE, launch a hop. pending is used first. Latch hop_dir, set counter = 0, clear pending, go to HOP.
  - HOP: each tick moves HOP_STEP/HOP_FRAMES along hop_dir, clamped. On the tick where counter = HOP_FRAMES-1: pulse hop_done, set counter = 0, go to COOL.
  - HOP and COOL: a tick with dir != NONE while pending == NONE latches pending = dir. The first press wins; later presses are dropped.
  - COOL: count ticks. After COOLDOWN ticks go to IDLE (COOLDOWN = 0 goes to IDLE on the next tick). The launch happens on the following tick.
- Drift on every tick in every state:
  - X += sign-extended lane_speed[lane_idx].
  - Zero drift when lane_idx = 4'hF.
  - Drift is added in the same cycle as any hop X step, before the clamp.
- edge_hit pulses when the pre-clamp X is < 0 or > X_LIM and drift != 0.
- lane_idx is combinational from the registered Y, using cy = Y + SIZE/2:
  - cy in [LANE_Y0, LANE_Y0 + NUM_LANES*LANE_H) gives lane = (cy - LANE_Y0)/LANE_H, built as a compare chain (no divider).
  - Otherwise lane_idx = 4'hF.
- A hop into a clamped edge still runs all HOP_FRAMES frames, with zero net movement along the clamped axis.
- hop_done and edge_hit are registered and last exactly one cycle.

Decomposition:
- Package frog_pkg holds:
  - typedef dir_t {NONE, UP, DOWN, LEFT, RIGHT}
  - typedef hop_state_t {IDLE, HOP, COOL}
  - coord_t = logic [10:0]
  - the clamp function
- One sub-module, frog_lane_lookup: Y to lane_idx compare chain plus lane_speed mux. It is purely combinational and parametrised on NUM_LANES, LANE_Y0, LANE_H, DRIFT_W.

Test Plan:
1. Release reset, all lane_speed = 0, hold up for 1 tick -> hopping rises. Y goes 435, 430, 425, 420 over 4 ticks, hop_done pulses on the 4th, then 2 COOL ticks, then IDLE.
2. Press left during tick 2 of a hop, then release -> pending = LEFT. First hop ends at Y=420; after COOL, a hop from X=320 ends at X=300.
3. Y=100 (lane 1, cy 110), lane_speed[1] = -3, X=2, no keys, one tick -> X=0 and edge_hit pulses for 1 cycle. Next tick: X=0, edge_hit pulses again.
4. Assert jump with (500, 200) during HOP counter=2, together with timer_done -> position = (500, 200), state IDLE, no hop_done pulse.
5. Assert reset_position and jump in the same cycle -> position = (320, 440), pending cleared.
6. Assert RESETn low mid-hop asynchronously -> outputs return to (320, 440) with no clock edge, hopping = 0. Y = Y_LIM and down pressed -> Y stays 460 for 4 frames, then hop_done.
